vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised VGA raster timing generator, successor to the fixed 640x480 controller.
//   Counts pixels and lines with configurable porches, sync widths and polarities.
//   Presents (x,y) to the pixel generator and delays sync/blank by PIX_LAT cycles so they
//   line up with the pipelined colour returned by the pixel generator.
//   Provides line/frame strobes and a frame counter, so the clock-face logic can update
//   hand positions between frames.
// PARAMETERS
//   H_ACTIVE   640  visible pixels per line
//   H_FP       16   horizontal front porch (pixels)
//   H_SYNC     96   hsync pulse width (pixels)
//   H_BP       48   horizontal back porch (pixels)
//   V_ACTIVE   480  visible lines per frame
//   V_FP       10   vertical front porch (lines)
//   V_SYNC     2    vsync pulse width (lines)
//   V_BP       33   vertical back porch (lines)
//   HS_POL     0    hsync active level (0 = active low)
//   VS_POL     0    vsync active level (0 = active low)
//   PIX_LAT    2    pixel-generator latency in enabled cycles, 0..15
//   CW         10   counter width; must hold max(HTOTAL,VTOTAL)-1
// PORTS
//   vgaclk       in   1   pixel clock
//   reset        in   1   synchronous, active-high reset
//   en           in   1   pixel enable; everything holds when 0
//   r_int        in   8   colour from pixel generator, valid PIX_LAT cycles after x/y
//   g_int        in   8   "
//   b_int        in   8   "
//   x            out  CW  current pixel column (= hcnt)
//   y            out  CW  current line (= vcnt)
//   line_start   out  1   one-en-cycle strobe at hcnt==0
//   frame_start  out  1   one-en-cycle strobe at hcnt==0 && vcnt==0
//   frame_cnt    out  16  completed-frame count, wraps mod 2^16
//   hsync        out  1   registered, polarity HS_POL
//   vsync        out  1   registered, polarity VS_POL
//   sync_b       out  1   composite sync, active low: 0 when hsync or vsync pulse active
//   blank_b      out  1   1 in active area, aligned with r/g/b
//   r, g, b      out  8   registered colour; forced to 0 when blank_b==0
// BEHAVIOUR
//   - HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, VTOTAL likewise. Line order: active, FP, sync, BP.
//   - hcnt counts 0..HTOTAL-1 on en. At HTOTAL-1, hcnt goes to 0 and vcnt increments.
//     At vcnt==VTOTAL-1 with that wrap, vcnt goes to 0 and frame_cnt increments.
//     No off-by-one: exactly HTOTAL states per line.
//   - Stage-0 signals (combinational from counters):
//     act  = hcnt<H_ACTIVE && vcnt<V_ACTIVE;
//     hs_p = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC);
//     vs_p = vcnt in the same window for the vertical parameters.
//   - {act,hs_p,vs_p} pass through a PIX_LAT-deep en-gated delay line, then the output
//     register. r/g/b are sampled at the output register.
//   - Latency: counter value n appears on hsync/vsync/blank_b/rgb exactly PIX_LAT+1 en
//     cycles later. rgb_int sampled on the same edge as the delayed act.
//   - line_start = en & (hcnt==0); frame_start = line_start & (vcnt==0).
//     Combinational from the counters and 0 while reset is high. They lead the outputs by
//     PIX_LAT+1 cycles.
//   - Reset (any time, including mid-line): next edge sets hcnt=vcnt=0 and frame_cnt=0.
//     All delay stages clear to inactive (act=0, hs_p=0, vs_p=0).
//     Outputs go to hsync=~HS_POL, vsync=~VS_POL, sync_b=1, blank_b=0, rgb=0.
//     First frame_start occurs in the first en cycle after reset falls.
//   - en low: counters, delay line and output registers hold; strobes are 0.
//   - reset has priority over en.
// STRUCTURE
//   - vga_pkg: default 640x480@60 timing constants, and a function computing HTOTAL/VTOTAL.
//   - Sub-module vga_delay_line #(W,DEPTH): en-gated shift register with sync reset.
//     DEPTH==0 is a pass-through.
// TESTING  (use small timing, e.g. H 8/2/2/2, V 4/1/1/1, PIX_LAT=2, unless stated)
//   - Free-run 3 frames:
//     line period = 14 en cycles, frame period = 14*7 = 98, frame_cnt 0->3.
//     hsync low for exactly 2 cycles per line.
//   - Latency: drive r_int = x[7:0].
//     First blank_b==1 output lands 3 cycles after x==0,y==0, and r==0 there.
//     r steps 0..7 across the line.
//   - Toggle en 1-0-1 randomly: output waveform equals the en=1 run with en=0 cycles deleted.
//     Strobes are never high while en=0.
//   - Assert reset at hcnt=5, vcnt=2 for 1 cycle:
//     next cycle x=y=0, frame_cnt=0, sync outputs inactive, rgb=0;
//     frame_start fires on the first en cycle after reset.
//   - HS_POL=1, VS_POL=1: hsync/vsync pulses are high; sync_b still low during either pulse.
//   - Defaults 640x480, PIX_LAT=0:
//     HTOTAL=800, VTOTAL=525; hsync low for hcnt 656..751; vsync active for lines 490..491;
//     x wraps 799->0.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA raster timing generator.
//   - Default 640x480@60 timing constants (pixels / lines).
//   - frame_total(): total states of one axis (active + porches + sync).
//   - sync_stage_t: the per-pixel control bits that travel down the delay
//     line alongside the pixel generator's colour pipeline.
//   No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Axis order is active, front porch, sync, back porch.
    function automatic int frame_total(input int active, input int fp,
                                       input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef struct packed {
        logic act;  // inside the visible area
        logic hs;   // inside the hsync pulse window (polarity-free)
        logic vs;   // inside the vsync pulse window (polarity-free)
    } sync_stage_t;

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
//   Enable-gated shift register with synchronous reset. Used to delay the
//   raster control bits so they line up with a pipelined pixel generator.
//   DEPTH == 0 degenerates to a wire.
// Ports:
//   clk    in   1  clock
//   reset  in   1  synchronous, active-high; clears every stage
//   en     in   1  shift enable; stages hold when low
//   d      in   W  data in
//   q      out  W  data delayed by DEPTH enabled cycles
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            // NOTE: every stage is reset, not just the tail, so a reset
            // mid-line cannot let stale sync pulses drain out afterwards.
            // NOTE: sequential state uses non-blocking assignment so each
            // stage takes its neighbour's pre-edge value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. Counts pixels/lines, presents
//   (x,y) to the pixel generator, and delays sync/blank by PIX_LAT enabled
//   cycles so they meet the colour coming back from it. All of hsync, vsync,
//   sync_b, blank_b and r/g/b come from one output register.
// Ports:
//   vgaclk       in   1   pixel clock
//   reset        in   1   synchronous, active-high
//   en           in   1   pixel enable; all state holds when low
//   r_int/g_int/b_int in 8 colour from pixel generator (PIX_LAT cycles after x/y)
//   x, y         out  CW  current column / line
//   line_start   out  1   strobe on the first pixel of each line
//   frame_start  out  1   strobe on the first pixel of each frame
//   frame_cnt    out  16  completed frames, wraps
//   hsync, vsync out  1   registered syncs, active level HS_POL / VS_POL
//   sync_b       out  1   composite sync, active low
//   blank_b      out  1   high in the visible area, aligned with r/g/b
//   r, g, b      out  8   registered colour, zero while blanked
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIX_LAT  = 2,
    parameter int   CW       = 10
) (
    input  logic          vgaclk,
    input  logic          reset,
    input  logic          en,
    input  logic [7:0]    r_int,
    input  logic [7:0]    g_int,
    input  logic [7:0]    b_int,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt,
    output logic          hsync,
    output logic          vsync,
    output logic          sync_b,
    output logic          blank_b,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
);

    localparam int HTOTAL = frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VTOTAL = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Counter-width copies of the window edges keep the compares width-clean.
    localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    sync_stage_t   s0;
    sync_stage_t   s_dly;

    // ---- raster counters -------------------------------------------------
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            hcnt      <= '0;
            vcnt      <= '0;
            frame_cnt <= '0;
        end else if (en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                if (vcnt == V_LAST) begin
                    vcnt      <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    vcnt <= vcnt + CW'(1);
                end
            end else begin
                hcnt <= hcnt + CW'(1);
            end
        end
    end

    assign x = hcnt;
    assign y = vcnt;

    // Strobes are unregistered, so they lead the video outputs by PIX_LAT+1.
    assign line_start  = en && !reset && (hcnt == '0);
    assign frame_start = line_start && (vcnt == '0);

    // ---- stage-0 decode --------------------------------------------------
    // NOTE: the struct gets a default before any conditional logic so this
    // block can never infer a latch.
    always_comb begin
        s0     = '0;
        s0.act = (hcnt < H_ACT) && (vcnt < V_ACT);
        s0.hs  = (hcnt >= HS_BEG) && (hcnt < HS_END);
        s0.vs  = (vcnt >= VS_BEG) && (vcnt < VS_END);
    end

    vga_delay_line #(
        .W     ($bits(sync_stage_t)),
        .DEPTH (PIX_LAT)
    ) u_dly (
        .clk   (vgaclk),
        .reset (reset),
        .en    (en),
        .d     (s0),
        .q     (s_dly)
    );

    // ---- output register: colour is sampled on the same edge as its act bit
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            hsync   <= ~HS_POL;
            vsync   <= ~VS_POL;
            sync_b  <= 1'b1;
            blank_b <= 1'b0;
            r       <= '0;
            g       <= '0;
            b       <= '0;
        end else if (en) begin
            hsync   <= s_dly.hs ? HS_POL : ~HS_POL;
            vsync   <= s_dly.vs ? VS_POL : ~VS_POL;
            sync_b  <= ~(s_dly.hs | s_dly.vs);
            blank_b <= s_dly.act;
            r       <= s_dly.act ? r_int : 8'd0;
            g       <= s_dly.act ? g_int : 8'd0;
            b       <= s_dly.act ? b_int : 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three instances share clock, reset and enable:
//     u_sml : 8/2/2/2 x 4/1/1/1, active-low syncs, PIX_LAT=2
//     u_pol : same timing, active-high syncs, PIX_LAT=0
//     u_def : 640x480 defaults, PIX_LAT=0
//   The reference model derives every output from the number of enabled
//   edges since the last reset, using plain division/modulo.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hpol, vpol;
        int lat;
    } timing_t;

    typedef struct {
        int x, y, frame;
        bit ls, fs, hsync, vsync, sync_b, blank_b;
        int r, g, b;
    } exp_t;

    localparam timing_t T_SML = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 2};
    localparam timing_t T_POL = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0};
    localparam timing_t T_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;

    int vectors    = 0;
    int miscompares = 0;
    int n_en       = 0;   // enabled edges since the last reset edge

    always #5 clk = ~clk;

    // ---- instance signals ------------------------------------------------
    logic [9:0]  s_x, s_y, p_x, p_y, d_x, d_y;
    logic        s_ls, s_fs, p_ls, p_fs, d_ls, d_fs;
    logic [15:0] s_fc, p_fc, d_fc;
    logic        s_hs, s_vs, s_sb, s_bb, p_hs, p_vs, p_sb, p_bb, d_hs, d_vs, d_sb, d_bb;
    logic [7:0]  s_r, s_g, s_b, p_r, p_g, p_b, d_r, d_g, d_b;
    logic [7:0]  s_ri, s_gi, s_bi;

    // Pixel generator for u_sml: colour = f(x,y) returned two enabled cycles later.
    logic [7:0] pg_x [2];
    logic [7:0] pg_y [2];
    always @(posedge clk) begin
        if (en && !reset) begin
            pg_x[0] <= s_x[7:0];
            pg_y[0] <= s_y[7:0];
            pg_x[1] <= pg_x[0];
            pg_y[1] <= pg_y[0];
        end
    end
    assign s_ri = pg_x[1];
    assign s_gi = pg_y[1];
    assign s_bi = ~pg_x[1];

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2), .CW(10)
    ) u_sml (
        .vgaclk(clk), .reset(reset), .en(en),
        .r_int(s_ri), .g_int(s_gi), .b_int(s_bi),
        .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc),
        .hsync(s_hs), .vsync(s_vs), .sync_b(s_sb), .blank_b(s_bb),
        .r(s_r), .g(s_g), .b(s_b)
    );

    // Zero-latency pixel generators: colour follows x/y directly.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0), .CW(10)
    ) u_pol (
        .vgaclk(clk), .reset(reset), .en(en),
        .r_int(p_x[7:0]), .g_int(p_y[7:0]), .b_int(~p_x[7:0]),
        .x(p_x), .y(p_y), .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc),
        .hsync(p_hs), .vsync(p_vs), .sync_b(p_sb), .blank_b(p_bb),
        .r(p_r), .g(p_g), .b(p_b)
    );

    vga_timing_gen #(
        .PIX_LAT(0)
    ) u_def (
        .vgaclk(clk), .reset(reset), .en(en),
        .r_int(d_x[7:0]), .g_int(d_y[7:0]), .b_int(~d_x[7:0]),
        .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc),
        .hsync(d_hs), .vsync(d_vs), .sync_b(d_sb), .blank_b(d_bb),
        .r(d_r), .g(d_g), .b(d_b)
    );

    // ---- checking ----------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: the raster position is just n split into pixel/line/frame;
    // the video outputs show the position from lat+1 enabled cycles ago.
    function automatic exp_t model(input int n, input bit en_now, input bit rst_now,
                                   input timing_t t);
        exp_t e;
        int   ht, vt, m, h, v;
        bit   act, hp, vp;
        ht      = t.ha + t.hfp + t.hsw + t.hbp;
        vt      = t.va + t.vfp + t.vsw + t.vbp;
        e.x     = n % ht;
        e.y     = (n / ht) % vt;
        e.frame = (n / (ht * vt)) % 65536;
        e.ls    = en_now && !rst_now && (e.x == 0);
        e.fs    = e.ls && (e.y == 0);
        m       = n - (t.lat + 1);
        act = 1'b0; hp = 1'b0; vp = 1'b0; h = 0; v = 0;
        if (m >= 0) begin
            h   = m % ht;
            v   = (m / ht) % vt;
            act = (h < t.ha) && (v < t.va);
            hp  = (h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hsw);
            vp  = (v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vsw);
        end
        e.hsync   = hp ? t.hpol : !t.hpol;
        e.vsync   = vp ? t.vpol : !t.vpol;
        e.sync_b  = !(hp || vp);
        e.blank_b = act;
        e.r       = act ? (h % 256) : 0;
        e.g       = act ? (v % 256) : 0;
        e.b       = act ? (255 - (h % 256)) : 0;
        return e;
    endfunction

    task automatic check_dut(input string nm, input timing_t t,
                             input logic [9:0] ox, input logic [9:0] oy,
                             input logic ols, input logic ofs, input logic [15:0] ofc,
                             input logic ohs, input logic ovs, input logic osb,
                             input logic obb, input logic [7:0] o_r,
                             input logic [7:0] o_g, input logic [7:0] o_b);
        exp_t e;
        e = model(n_en, en, reset, t);
        check({nm, ".x"},           32'(ox),  32'(e.x));
        check({nm, ".y"},           32'(oy),  32'(e.y));
        check({nm, ".line_start"},  32'(ols), 32'(e.ls));
        check({nm, ".frame_start"}, 32'(ofs), 32'(e.fs));
        check({nm, ".frame_cnt"},   32'(ofc), 32'(e.frame));
        check({nm, ".hsync"},       32'(ohs), 32'(e.hsync));
        check({nm, ".vsync"},       32'(ovs), 32'(e.vsync));
        check({nm, ".sync_b"},      32'(osb), 32'(e.sync_b));
        check({nm, ".blank_b"},     32'(obb), 32'(e.blank_b));
        check({nm, ".r"},           32'(o_r), 32'(e.r));
        check({nm, ".g"},           32'(o_g), 32'(e.g));
        check({nm, ".b"},           32'(o_b), 32'(e.b));
    endtask

    // One clock: the edge consumes the current reset/en, then the next values
    // are driven and all instances are checked mid-cycle on the falling edge.
    task automatic step(input bit nrst, input bit nen);
        @(posedge clk);
        if (reset)   n_en = 0;
        else if (en) n_en++;
        #1;
        reset = nrst;
        en    = nen;
        @(negedge clk);
        check_dut("sml", T_SML, s_x, s_y, s_ls, s_fs, s_fc, s_hs, s_vs, s_sb, s_bb, s_r, s_g, s_b);
        check_dut("pol", T_POL, p_x, p_y, p_ls, p_fs, p_fc, p_hs, p_vs, p_sb, p_bb, p_r, p_g, p_b);
        check_dut("def", T_DEF, d_x, d_y, d_ls, d_fs, d_fc, d_hs, d_vs, d_sb, d_bb, d_r, d_g, d_b);
    endtask

    int hs_low;
    int waited;

    initial begin
        // Reset with en low, then release into a free run of three small frames.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("first_frame_start", 32'(s_fs), 32'd1);
        hs_low = 0;
        for (int i = 0; i < 3 * 98; i++) begin
            step(1'b0, 1'b1);
            if (s_hs == 1'b0) hs_low++;
        end
        check("sml.frames_after_294", 32'(s_fc), 32'd3);
        // Output trails the counters by 3, so 294 sampled cycles span 21 full pulses.
        check("sml.hsync_low_cycles", 32'(hs_low), 32'(21 * 2));

        // Random enable gaps.
        for (int i = 0; i < 600; i++) begin
            step(1'b0, ($urandom_range(0, 99) < 65));
        end

        // Reset for one cycle while the small raster sits at hcnt=5, vcnt=2.
        waited = 0;
        while (!(s_x == 10'd4 && s_y == 10'd2) && waited < 200) begin
            step(1'b0, 1'b1);
            waited++;
        end
        check("wait_for_x4_y2_timeout", 32'(waited < 200), 32'd1);
        step(1'b1, 1'b1);
        check("pre_reset_x", 32'(s_x), 32'd5);
        step(1'b0, 1'b1);
        check("post_reset_x",  32'(s_x),  32'd0);
        check("post_reset_y",  32'(s_y),  32'd0);
        check("post_reset_fc", 32'(s_fc), 32'd0);
        check("post_reset_hs", 32'(s_hs), 32'd1);
        check("post_reset_r",  32'(s_r),  32'd0);
        check("post_reset_fs", 32'(s_fs), 32'd1);

        // Free run long enough for two full default-timing lines.
        for (int i = 0; i < 1700; i++) begin
            step(1'b0, 1'b1);
        end
        check("def.frame_cnt_steady", 32'(d_fc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
